// File: rtl/pipe_controller.sv
// Main controller for the five-stage MIPS pipeline: D-stage decode, E/M/W control
// pipeline registers, and the mult/div busy counter that drives the D-stage stall.
module pipe_controller #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    input  logic        stall_ext,
    output logic        stall_d,
    output logic [2:0]  npc_sel_d,
    output logic [1:0]  cmp_op_d,
    output logic        ext_op_d,
    output logic [3:0]  alu_op_e,
    output logic [1:0]  alu_src_e,
    output logic [2:0]  md_op_e,
    output logic        md_start_e,
    output logic        md_busy,
    output logic        reg_write_e,
    output logic        reg_write_m,
    output logic        reg_write_w,
    output logic [1:0]  wa_sel_e,
    output logic [1:0]  wa_sel_m,
    output logic [1:0]  wa_sel_w,
    output logic [1:0]  wd_sel_m,
    output logic [1:0]  wd_sel_w,
    output logic        mem_read_m,
    output logic        mem_write_m
);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wa_sel;
        logic [1:0] wd_sel;
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic [2:0] md_op;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ORI  = 6'b001101, OP_ANDI = 6'b001100,
                           OP_ADDIU = 6'b001001, OP_LUI  = 6'b001111, OP_LW   = 6'b100011,
                           OP_SW    = 6'b101011, OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101,
                           OP_J     = 6'b000010, OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_AND  = 6'b100100,
                           FN_OR   = 6'b100101, FN_SLT  = 6'b101010, FN_SLL  = 6'b000000,
                           FN_JR   = 6'b001000, FN_JALR = 6'b001001, FN_MFHI = 6'b010000,
                           FN_MTHI = 6'b010001, FN_MFLO = 6'b010010, FN_MTLO = 6'b010011,
                           FN_MULT = 6'b011000, FN_MULTU = 6'b011001, FN_DIV = 6'b011010,
                           FN_DIVU = 6'b011011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_OR = 4'd3,
                           ALU_LUI = 4'd4, ALU_LINK = 4'd5, ALU_AND = 4'd6, ALU_SLT = 4'd7;
    localparam logic [1:0] SRC_IMM = 2'd1, SRC_PC = 2'd2;
    localparam logic [1:0] WA_RT = 2'd0, WA_RD = 2'd1, WA_RA = 2'd2;
    localparam logic [1:0] WD_MEM = 2'd1, WD_HI = 2'd2, WD_LO = 2'd3;
    localparam logic [2:0] MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV = 3'd3, MD_DIVU = 3'd4,
                           MD_MTHI = 3'd5, MD_MTLO = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    logic [5:0] opcode;
    logic [5:0] funct;
    ctrl_t      ctrl_d;
    logic       md_class_d;
    logic       md_hazard;
    ctrl_t      stage_reg [3];
    logic [3:0] md_count_reg;
    logic       unused_bits;

    assign opcode = instr_d[31:26];
    assign funct  = instr_d[5:0];

    always_comb begin
        ctrl_d     = '0;
        npc_sel_d  = 3'd0;
        cmp_op_d   = 2'd0;
        ext_op_d   = 1'b0;
        md_class_d = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADDU: begin ctrl_d.reg_write = 1'b1; ctrl_d.wa_sel = WA_RD; ctrl_d.alu_op = ALU_ADD; end
                FN_SUBU: begin ctrl_d.reg_write = 1'b1; ctrl_d.wa_sel = WA_RD; ctrl_d.alu_op = ALU_SUB; end
                FN_AND:  begin ctrl_d.reg_write = 1'b1; ctrl_d.wa_sel = WA_RD; ctrl_d.alu_op = ALU_AND; end
                FN_OR:   begin ctrl_d.reg_write = 1'b1; ctrl_d.wa_sel = WA_RD; ctrl_d.alu_op = ALU_OR;  end
                FN_SLT:  begin ctrl_d.reg_write = 1'b1; ctrl_d.wa_sel = WA_RD; ctrl_d.alu_op = ALU_SLT; end
                FN_SLL:  begin ctrl_d.reg_write = 1'b1; ctrl_d.wa_sel = WA_RD; ctrl_d.alu_op = ALU_SLL; end
                FN_JR:   npc_sel_d = 3'd3;
                FN_JALR: begin
                    npc_sel_d        = 3'd3;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.wa_sel    = WA_RD;
                    ctrl_d.alu_op    = ALU_LINK;
                    ctrl_d.alu_src   = SRC_PC;
                end
                FN_MFHI: begin md_class_d = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.wa_sel = WA_RD; ctrl_d.wd_sel = WD_HI; end
                FN_MFLO: begin md_class_d = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.wa_sel = WA_RD; ctrl_d.wd_sel = WD_LO; end
                FN_MTHI:  begin md_class_d = 1'b1; ctrl_d.md_op = MD_MTHI;  end
                FN_MTLO:  begin md_class_d = 1'b1; ctrl_d.md_op = MD_MTLO;  end
                FN_MULT:  begin md_class_d = 1'b1; ctrl_d.md_op = MD_MULT;  end
                FN_MULTU: begin md_class_d = 1'b1; ctrl_d.md_op = MD_MULTU; end
                FN_DIV:   begin md_class_d = 1'b1; ctrl_d.md_op = MD_DIV;   end
                FN_DIVU:  begin md_class_d = 1'b1; ctrl_d.md_op = MD_DIVU;  end
                default: ;
            endcase
        end else begin
            case (opcode)
                OP_ORI:   begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_op = ALU_OR;  ctrl_d.alu_src = SRC_IMM; end
                OP_ANDI:  begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_op = ALU_AND; ctrl_d.alu_src = SRC_IMM; end
                OP_ADDIU: begin
                    ext_op_d = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.alu_op = ALU_ADD; ctrl_d.alu_src = SRC_IMM;
                end
                OP_LUI:   begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_op = ALU_LUI; ctrl_d.alu_src = SRC_IMM; end
                OP_LW: begin
                    ext_op_d         = 1'b1;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.wa_sel    = WA_RT;
                    ctrl_d.wd_sel    = WD_MEM;
                    ctrl_d.alu_src   = SRC_IMM;
                    ctrl_d.mem_read  = 1'b1;
                end
                OP_SW:  begin ext_op_d = 1'b1; ctrl_d.alu_src = SRC_IMM; ctrl_d.mem_write = 1'b1; end
                OP_BEQ: begin ext_op_d = 1'b1; npc_sel_d = 3'd1; cmp_op_d = 2'd1; end
                OP_BNE: begin ext_op_d = 1'b1; npc_sel_d = 3'd1; cmp_op_d = 2'd2; end
                OP_J:   npc_sel_d = 3'd2;
                OP_JAL: begin
                    npc_sel_d        = 3'd2;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.wa_sel    = WA_RA;
                    ctrl_d.alu_op    = ALU_LINK;
                    ctrl_d.alu_src   = SRC_PC;
                end
                default: ;
            endcase
        end
    end

    // Any md-class instruction must wait in D while the MD unit is occupied.
    assign md_hazard = md_class_d & md_busy;
    assign stall_d   = stall_ext | md_hazard;

    // A stalled D stage injects a bubble into E; E, M and W always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) stage_reg[i] <= '0;
        end else begin
            stage_reg[0] <= stall_d ? ctrl_t'('0) : ctrl_d;
            for (int i = 1; i < 3; i++) stage_reg[i] <= stage_reg[i-1];
        end
    end

    assign md_start_e = (md_op_e >= MD_MULT) && (md_op_e <= MD_DIVU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            md_count_reg <= 4'd0;
        else if (md_start_e)
            md_count_reg <= (md_op_e == MD_MULT || md_op_e == MD_MULTU) ? MULT_CNT : DIV_CNT;
        else if (md_count_reg != 4'd0)
            md_count_reg <= md_count_reg - 4'd1;
    end

    assign md_busy = md_start_e | (md_count_reg != 4'd0);

    assign alu_op_e    = stage_reg[0].alu_op;
    assign alu_src_e   = stage_reg[0].alu_src;
    assign md_op_e     = stage_reg[0].md_op;
    assign reg_write_e = stage_reg[0].reg_write;
    assign wa_sel_e    = stage_reg[0].wa_sel;
    assign reg_write_m = stage_reg[1].reg_write;
    assign wa_sel_m    = stage_reg[1].wa_sel;
    assign wd_sel_m    = stage_reg[1].wd_sel;
    assign mem_read_m  = stage_reg[1].mem_read;
    assign mem_write_m = stage_reg[1].mem_write;
    assign reg_write_w = stage_reg[2].reg_write;
    assign wa_sel_w    = stage_reg[2].wa_sel;
    assign wd_sel_w    = stage_reg[2].wd_sel;

    assign unused_bits = ^{instr_d[25:6], stage_reg[0], stage_reg[1], stage_reg[2]};

endmodule

// File: tb/tb_pipe_controller.sv
// Randomised bench for pipe_controller: a mnemonic-level reference model predicts every
// output each cycle, and directed sequences pin the model with hand-computed values.
module tb_pipe_controller;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_d = 32'd0;
    logic        stall_ext = 1'b0;
    logic        stall_d, ext_op_d, md_start_e, md_busy;
    logic [2:0]  npc_sel_d, md_op_e;
    logic [1:0]  cmp_op_d, alu_src_e;
    logic [3:0]  alu_op_e;
    logic        reg_write_e, reg_write_m, reg_write_w, mem_read_m, mem_write_m;
    logic [1:0]  wa_sel_e, wa_sel_m, wa_sel_w, wd_sel_m, wd_sel_w;

    pipe_controller #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .stall_ext(stall_ext),
        .stall_d(stall_d), .npc_sel_d(npc_sel_d), .cmp_op_d(cmp_op_d), .ext_op_d(ext_op_d),
        .alu_op_e(alu_op_e), .alu_src_e(alu_src_e), .md_op_e(md_op_e), .md_start_e(md_start_e),
        .md_busy(md_busy), .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
        .reg_write_w(reg_write_w), .wa_sel_e(wa_sel_e), .wa_sel_m(wa_sel_m), .wa_sel_w(wa_sel_w),
        .wd_sel_m(wd_sel_m), .wd_sel_w(wd_sel_w), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m)
    );

    always #5 clk = ~clk;

    typedef enum int {
        M_NOP, M_ADDU, M_SUBU, M_AND, M_OR, M_SLT, M_SLL, M_JR, M_JALR,
        M_MULT, M_MULTU, M_DIV, M_DIVU, M_MFHI, M_MFLO, M_MTHI, M_MTLO,
        M_ORI, M_ANDI, M_ADDIU, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL
    } mnem_t;

    typedef struct packed {
        logic       rw;
        logic [1:0] wa;
        logic [1:0] wd;
        logic [3:0] alu;
        logic [1:0] src;
        logic [2:0] md;
        logic       mr;
        logic       mw;
    } cw_t;

    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    busy_until = -1000;
    cw_t   exp_st [3];
    cw_t   next_cw;
    logic  exp_stall;
    logic  last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic mnem_t classify(input logic [31:0] w);
        mnem_t m;
        m = M_NOP;
        if (w[31:26] == 6'b000000) begin
            case (w[5:0])
                6'b100001: m = M_ADDU;  6'b100011: m = M_SUBU;  6'b100100: m = M_AND;
                6'b100101: m = M_OR;    6'b101010: m = M_SLT;   6'b000000: m = M_SLL;
                6'b001000: m = M_JR;    6'b001001: m = M_JALR;  6'b010000: m = M_MFHI;
                6'b010001: m = M_MTHI;  6'b010010: m = M_MFLO;  6'b010011: m = M_MTLO;
                6'b011000: m = M_MULT;  6'b011001: m = M_MULTU; 6'b011010: m = M_DIV;
                6'b011011: m = M_DIVU;
                default: m = M_NOP;
            endcase
        end else begin
            case (w[31:26])
                6'b001101: m = M_ORI;  6'b001100: m = M_ANDI; 6'b001001: m = M_ADDIU;
                6'b001111: m = M_LUI;  6'b100011: m = M_LW;   6'b101011: m = M_SW;
                6'b000100: m = M_BEQ;  6'b000101: m = M_BNE;  6'b000010: m = M_J;
                6'b000011: m = M_JAL;
                default: m = M_NOP;
            endcase
        end
        return m;
    endfunction

    function automatic logic [31:0] encode(input mnem_t m);
        logic [31:0] w;
        logic [5:0]  code;
        logic        rtype;
        w = $urandom;
        rtype = 1'b1;
        code = 6'd0;
        case (m)
            M_ADDU: code = 6'b100001;  M_SUBU: code = 6'b100011;  M_AND: code = 6'b100100;
            M_OR:   code = 6'b100101;  M_SLT:  code = 6'b101010;  M_SLL: code = 6'b000000;
            M_JR:   code = 6'b001000;  M_JALR: code = 6'b001001;  M_MFHI: code = 6'b010000;
            M_MTHI: code = 6'b010001;  M_MFLO: code = 6'b010010;  M_MTLO: code = 6'b010011;
            M_MULT: code = 6'b011000;  M_MULTU: code = 6'b011001; M_DIV: code = 6'b011010;
            M_DIVU: code = 6'b011011;
            default: begin
                rtype = 1'b0;
                case (m)
                    M_ORI: code = 6'b001101;  M_ANDI: code = 6'b001100; M_ADDIU: code = 6'b001001;
                    M_LUI: code = 6'b001111;  M_LW:   code = 6'b100011; M_SW:    code = 6'b101011;
                    M_BEQ: code = 6'b000100;  M_BNE:  code = 6'b000101; M_J:     code = 6'b000010;
                    M_JAL: code = 6'b000011;
                    default: code = 6'b111111;
                endcase
            end
        endcase
        if (rtype) begin
            w[31:26] = 6'd0;
            w[5:0]   = code;
        end else begin
            w[31:26] = code;
        end
        return w;
    endfunction

    // Control word implied by each mnemonic's write-back, ALU and memory behaviour.
    function automatic cw_t ref_cw(input mnem_t m);
        cw_t c;
        c = '0;
        case (m)
            M_ADDU, M_SUBU, M_AND, M_OR, M_SLT, M_SLL, M_JALR, M_MFHI, M_MFLO: begin
                c.rw = 1'b1; c.wa = 2'd1;
            end
            M_ORI, M_ANDI, M_ADDIU, M_LUI, M_LW: begin
                c.rw = 1'b1; c.wa = 2'd0; c.src = 2'd1;
            end
            M_JAL: begin c.rw = 1'b1; c.wa = 2'd2; end
            M_SW: begin c.src = 2'd1; c.mw = 1'b1; end
            default: ;
        endcase
        case (m)
            M_SUBU: c.alu = 4'd1;
            M_SLL: c.alu = 4'd2;
            M_OR, M_ORI: c.alu = 4'd3;
            M_LUI: c.alu = 4'd4;
            M_JAL, M_JALR: begin c.alu = 4'd5; c.src = 2'd2; end
            M_AND, M_ANDI: c.alu = 4'd6;
            M_SLT: c.alu = 4'd7;
            default: ;
        endcase
        case (m)
            M_LW: begin c.wd = 2'd1; c.mr = 1'b1; end
            M_MFHI: c.wd = 2'd2;
            M_MFLO: c.wd = 2'd3;
            M_MULT: c.md = 3'd1;  M_MULTU: c.md = 3'd2; M_DIV: c.md = 3'd3;
            M_DIVU: c.md = 3'd4;  M_MTHI: c.md = 3'd5;  M_MTLO: c.md = 3'd6;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] ref_npc(input mnem_t m);
        if (m == M_BEQ || m == M_BNE) return 3'd1;
        if (m == M_J || m == M_JAL) return 3'd2;
        if (m == M_JR || m == M_JALR) return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [1:0] ref_cmp(input mnem_t m);
        return (m == M_BEQ) ? 2'd1 : (m == M_BNE) ? 2'd2 : 2'd0;
    endfunction

    function automatic logic ref_ext(input mnem_t m);
        return m inside {M_LW, M_SW, M_BEQ, M_BNE, M_ADDIU};
    endfunction

    function automatic logic is_md_class(input mnem_t m);
        return m inside {M_MULT, M_MULTU, M_DIV, M_DIVU, M_MFHI, M_MFLO, M_MTHI, M_MTLO};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) exp_st[i] = '0;
        busy_until = -1000;
    endtask

    task automatic compare_all();
        mnem_t m;
        logic  exp_start, exp_busy;
        m = classify(instr_d);
        next_cw = ref_cw(m);
        exp_start = (exp_st[0].md >= 3'd1) && (exp_st[0].md <= 3'd4);
        // Busy spans the start cycle plus LAT further cycles.
        if (exp_start) busy_until = cyc + ((exp_st[0].md <= 3'd2) ? MULT_LAT : DIV_LAT);
        exp_busy  = exp_start || (cyc <= busy_until);
        exp_stall = stall_ext | (is_md_class(m) & exp_busy);
        chk("stall_d", stall_d, exp_stall);
        chk("npc_sel_d", npc_sel_d, ref_npc(m));
        chk("cmp_op_d", cmp_op_d, ref_cmp(m));
        chk("ext_op_d", ext_op_d, ref_ext(m));
        chk("alu_op_e", alu_op_e, exp_st[0].alu);
        chk("alu_src_e", alu_src_e, exp_st[0].src);
        chk("md_op_e", md_op_e, exp_st[0].md);
        chk("md_start_e", md_start_e, exp_start);
        chk("md_busy", md_busy, exp_busy);
        chk("reg_write_e", reg_write_e, exp_st[0].rw);
        chk("wa_sel_e", wa_sel_e, exp_st[0].wa);
        chk("reg_write_m", reg_write_m, exp_st[1].rw);
        chk("wa_sel_m", wa_sel_m, exp_st[1].wa);
        chk("wd_sel_m", wd_sel_m, exp_st[1].wd);
        chk("mem_read_m", mem_read_m, exp_st[1].mr);
        chk("mem_write_m", mem_write_m, exp_st[1].mw);
        chk("reg_write_w", reg_write_w, exp_st[2].rw);
        chk("wa_sel_w", wa_sel_w, exp_st[2].wa);
        chk("wd_sel_w", wd_sel_w, exp_st[2].wd);
    endtask

    task automatic finish_cycle();
        compare_all();
        last_stall = stall_d;
        $display("cyc %0d instr %08h stall_ext %0b stall_d %0b md_busy %0b", cyc, instr_d, stall_ext, stall_d, md_busy);
        @(posedge clk);
        exp_st[2] = exp_st[1];
        exp_st[1] = exp_st[0];
        exp_st[0] = exp_stall ? cw_t'('0) : next_cw;
        cyc++;
    endtask

    task automatic step(input logic [31:0] w, input logic s);
        @(negedge clk);
        instr_d   = w;
        stall_ext = s;
        #1;
        finish_cycle();
    endtask

    function automatic logic [31:0] stage_outs();
        return {7'd0, alu_op_e, alu_src_e, md_op_e, md_start_e, reg_write_e, reg_write_m, reg_write_w,
                wa_sel_e, wa_sel_m, wa_sel_w, wd_sel_m, wd_sel_w, mem_read_m, mem_write_m};
    endfunction

    // Called just after a rising edge: pulses rst_n low for half a cycle.
    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        instr_d = encode(M_MFHI);
        stall_ext = 1'b0;
        #1;
        chk("rst_md_busy", md_busy, 1'b0);
        chk("rst_stage_outs", stage_outs(), 32'd0);
        chk("rst_stall_md", stall_d, 1'b0);
        stall_ext = 1'b1;
        #1;
        chk("rst_stall_ext", stall_d, 1'b1);
        stall_ext = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        #1;
        finish_cycle();
        chk("post_rst_mfhi_unstalled", last_stall, 1'b0);
    endtask

    logic [31:0] nop_w, w_rand;
    int ns;

    initial begin
        model_reset();
        nop_w = encode(M_NOP);
        instr_d = encode(M_MULT);
        stall_ext = 1'b1;
        #2;
        chk("reset_stall_follows_ext", stall_d, 1'b1);
        chk("reset_md_busy", md_busy, 1'b0);
        chk("reset_stage_outs", stage_outs(), 32'd0);
        stall_ext = 1'b0;
        #1;
        chk("reset_stall_low", stall_d, 1'b0);
        instr_d = nop_w;
        #9;
        rst_n = 1'b1;
        #1;
        finish_cycle();

        // addu: rd write through E and W
        step(encode(M_ADDU), 1'b0);
        #2;
        chk("addu_reg_write_e", reg_write_e, 1'b1);
        chk("addu_wa_sel_e", wa_sel_e, 2'd1);
        chk("addu_alu_op_e", alu_op_e, 4'd0);
        step(nop_w, 1'b0);
        step(nop_w, 1'b0);
        #2;
        chk("addu_reg_write_w", reg_write_w, 1'b1);
        chk("addu_wd_sel_w", wd_sel_w, 2'd0);

        // lw then jal
        step(encode(M_LW), 1'b0);
        #2;
        chk("lw_ext_op_d", ext_op_d, 1'b1);
        step(encode(M_JAL), 1'b0);
        #2;
        chk("jal_npc_sel_d", npc_sel_d, 3'd2);
        chk("lw_mem_read_m", mem_read_m, 1'b1);
        chk("jal_wa_sel_e", wa_sel_e, 2'd2);
        chk("jal_alu_op_e", alu_op_e, 4'd5);
        chk("jal_alu_src_e", alu_src_e, 2'd2);
        step(nop_w, 1'b0);
        #2;
        chk("lw_wd_sel_w", wd_sel_w, 2'd1);
        step(nop_w, 1'b0);

        // mult then mflo: six stalled cycles, then mflo flows to W
        step(encode(M_MULT), 1'b0);
        #2;
        chk("mult_md_start_e", md_start_e, 1'b1);
        ns = 0;
        step(encode(M_MFLO), 1'b0);
        while (last_stall && ns < 20) begin
            ns++;
            step(encode(M_MFLO), 1'b0);
        end
        chk("mult_stall_cycles", ns, 6);
        step(nop_w, 1'b0);
        step(nop_w, 1'b0);
        #2;
        chk("mflo_wd_sel_w", wd_sel_w, 2'd3);

        // div (latency 3), addu passes, mfhi waits three cycles
        step(encode(M_DIVU), 1'b0);
        step(encode(M_ADDU), 1'b0);
        chk("div_addu_unstalled", last_stall, 1'b0);
        ns = 0;
        step(encode(M_MFHI), 1'b0);
        while (last_stall && ns < 20) begin
            ns++;
            step(encode(M_MFHI), 1'b0);
        end
        chk("div_mfhi_stall_cycles", ns, 3);

        // reset in the middle of a div busy period
        step(encode(M_DIV), 1'b0);
        async_reset_pulse();

        // external stall holding beq in D
        step(encode(M_ADDU), 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(encode(M_BEQ), 1'b1);
            #2;
            chk("beq_cmp_op_d", cmp_op_d, 2'd1);
            chk("beq_npc_sel_d", npc_sel_d, 3'd1);
            chk("beq_bubble_e", {reg_write_e, wa_sel_e, alu_op_e, alu_src_e, md_op_e}, 12'd0);
        end
        step(encode(M_BEQ), 1'b0);
        #2;
        chk("beq_reg_write_e", reg_write_e, 1'b0);

        // randomised traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) w_rand = $urandom;
            else w_rand = encode(mnem_t'($urandom_range(0, 26)));
            step(w_rand, $urandom_range(0, 4) == 0);
            if (i % 700 == 699) async_reset_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Pipelined main controller for the P6 five-stage MIPS core. Decodes the D-stage instruction, then carries its control word through E, M and W in its own pipeline registers. Owns the multiply/divide busy counter and raises the D-stage stall for mult/div-class hazards. Sits beside the datapath and feeds the ALU, the MD unit, the DM and the GRF write-back mux.

## Interface
- `MULT_LAT`, 5: busy cycles after a mult/multu issues from E (1..15).
- `DIV_LAT`, 10: busy cycles after a div/divu issues from E (1..15).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_d` in 32: D-stage instruction word.
- `stall_ext` in 1: data-hazard stall from the hazard unit.
- `stall_d` out 1: freeze PC/D. Equals `stall_ext | md_hazard`.
- `npc_sel_d` out 3: 0 pc+4, 1 branch, 2 j/jal, 3 jr/jalr. Combinational.
- `cmp_op_d` out 2: 0 none, 1 eq (beq), 2 ne (bne). Combinational.
- `ext_op_d` out 1: 1 selects sign-extend. Set for lw, sw, beq, bne, addiu. Combinational.
- `alu_op_e` out 4: 0 add, 1 sub, 2 sll, 3 or, 4 lui, 5 link (pc+8), 6 and, 7 slt.
- `alu_src_e` out 2: 0 rt, 1 imm, 2 pc.
- `md_op_e` out 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- `md_start_e` out 1: E holds mult/multu/div/divu.
- `md_busy` out 1: MD unit is occupied.
- `reg_write_e` out 1, `reg_write_m` out 1, `reg_write_w` out 1: GRF write enable per stage, used for forwarding.
- `wa_sel_e` out 2, `wa_sel_m` out 2, `wa_sel_w` out 2: 0 rt, 1 rd, 2 $31.
- `wd_sel_m` out 2, `wd_sel_w` out 2: 0 alu, 1 mem, 2 hi, 3 lo.
- `mem_read_m` out 1, `mem_write_m` out 1: DM controls.

## Operation
- Supported set:
  - R-type: addu, subu, and, or, slt, sll, jr, jalr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
  - I/J-type: ori, andi, addiu, lui, lw, sw, beq, bne, j, jal.
- Func codes:
  - addu 100001, subu 100011, and 100100, or 100101, slt 101010.
  - sll 000000, jr 001000, jalr 001001.
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
  - mult 011000, multu 011001, div 011010, divu 011011.
- Opcodes: ori 001101, andi 001100, addiu 001001, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
- Unrecognised words decode to an all-zero control word (nop): no register write, no memory access, npc_sel 0.
- Write-back rules:
  - R-ALU ops, jalr, mfhi and mflo write rd.
  - ori, andi, addiu, lui and lw write rt.
  - jal writes $31 with alu_op 5 and alu_src 2.
  - jr, sw, branches, j, mult/div and mthi/mtlo do not write.
- Pipeline registers D→E, E→M and M→W advance every cycle.
  - When `stall_d`=1, the D→E register loads a nop bubble. E, M and W keep advancing.
- md-class means mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- `md_hazard` = (instr_d is md-class) & `md_busy`.
- Busy counter (4 bits):
  - On a cycle with `md_start_e`=1, it loads MULT_LAT for mult/multu or DIV_LAT for div/divu.
  - Otherwise it decrements while nonzero and saturates at 0.
- `md_busy` = `md_start_e` | (count != 0).
- mthi and mtlo never load the counter.

## Timing
- Reset (rst_n=0, asynchronous): all E/M/W registers become nop and the counter becomes 0.
  - While reset is held: every registered output is 0, `md_busy`=0, and `stall_d` = `stall_ext`.
- A reset asserted mid-operation drops any outstanding busy period immediately.
- The D-stage outputs are combinational from `instr_d`, with zero latency.
- Latency from D to stage outputs: E 1 cycle, M 2 cycles, W 3 cycles.
- Mult entering E at cycle t: `md_busy`=1 for cycles t .. t+MULT_LAT and 0 at t+MULT_LAT+1 (MULT_LAT+1 cycles total).
  - Div behaves the same with DIV_LAT.
- The counter keeps decrementing during stalls, whether from `stall_ext` or `md_hazard`.
- If `stall_ext` and `md_hazard` are both high, `stall_d`=1. A single bubble is inserted per stalled cycle.
- A new md-class instruction reaches E only after `md_busy` has fallen. Two start events therefore cannot overlap.

## Test plan
- Reset, then drive addu (00000000 + func 100001) → next cycle `reg_write_e`=1, `wa_sel_e`=1, `alu_op_e`=0. Two cycles later `reg_write_w`=1, `wd_sel_w`=0.
- Drive lw, then jal → for lw: `ext_op_d`=1, then `mem_read_m`=1 and `wd_sel_w`=1. For jal: `npc_sel_d`=2, `wa_sel_e`=2, `alu_op_e`=5, `alu_src_e`=2.
- Drive mult, then mflo, default MULT_LAT=5 → `md_start_e`=1 at t. `stall_d`=1 for cycles t..t+5, with E holding a nop. mflo reaches E at t+7 and gives `wd_sel_w`=3 at t+9.
- Drive div, with DIV_LAT overridden to 3, then addu, then mfhi → addu is not stalled. mfhi stalls until `md_busy` falls after t+3.
- Pulse rst_n low for half a cycle during a div busy period → `md_busy`=0 and all stage outputs 0 asynchronously. After release, the next mfhi passes unstalled.
- Drive `stall_ext`=1 for 2 cycles with beq in D (`cmp_op_d`=1, `npc_sel_d`=1) → two nop bubbles appear in E. beq then proceeds, and `reg_write_e`=0 throughout.
